uart_tx_scheduler: RTL and testbench

- Shares one UART_Transmitter among N_REQ byte requesters using round-robin arbitration.
- Sequences the transmitter handshake for each granted byte: b_ready, then load_data with data_bus, then t_init.
- Holds the transmitter for a fixed frame time plus a guard gap before the next grant, because the transmitter has no busy/done output.
- Sits between requester blocks (host, error injector path) and UART_Transmitter.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_scheduler_if.sv | 12 +
 rtl/uart_rr_arbiter.sv | 28 ++
 rtl/uart_tx_scheduler.sv | 91 +++++++++
 tb/tb_uart_tx_scheduler.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: state encoding and byte geometry.
package uart_pkg;

  localparam int BYTE_W           = 8;
  localparam int MIN_FRAME_CYCLES = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_BUSY  = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Handshake bundle between the scheduler and the shared UART_Transmitter.
interface uart_tx_scheduler_if;

  logic [uart_pkg::BYTE_W-1:0] tx_data_bus;
  logic                        tx_b_ready;
  logic                        tx_load_data;
  logic                        tx_t_init;

  modport master (output tx_data_bus, output tx_b_ready, output tx_load_data, output tx_t_init);
  modport slave  (input  tx_data_bus, input  tx_b_ready, input  tx_load_data, input  tx_t_init);

endinterface

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin select: first set request at or above ptr, wrapping at N_REQ.
module uart_rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       ptr,
  output logic [2:0]       winner,
  output logic             valid
);

  always_comb begin
    int               idx;
    logic [N_REQ-1:0] sh;
    idx    = 0;
    sh     = '0;
    winner = '0;
    valid  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      sh  = req >> idx;
      if (!valid && sh[0]) begin
        valid  = 1'b1;
        winner = 3'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART_Transmitter among N_REQ byte requesters,
// sequencing b_ready/load_data/t_init and holding the line for frame plus guard time.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int FRAME_CYCLES = 10,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    enable,
  input  logic [N_REQ-1:0]        req,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]        ack,
  output logic [2:0]              grant_id,
  output logic                    busy,
  output logic                    tx_done,
  uart_tx_scheduler_if.master     tx
);

  localparam int CNT_MAX = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [BYTE_W-1:0]      byte_q;
  logic [2:0]             ptr_q;
  logic [2:0]             winner;
  logic                   win_vld;
  logic                   grant;
  logic [BYTE_W*N_REQ-1:0] data_sh;

  uart_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req    (req),
    .ptr    (ptr_q),
    .winner (winner),
    .valid  (win_vld)
  );

  assign grant   = (state_q == ST_IDLE) && enable && win_vld;
  assign data_sh = req_data >> (BYTE_W * int'(winner));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (grant) state_d = ST_ARM;
      ST_ARM:   state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_START;
      ST_START: state_d = ST_BUSY;
      ST_BUSY:  if (cnt_q == '0) state_d = ST_GAP;
      ST_GAP:   if (cnt_q == '0) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      byte_q   <= '0;
      ptr_q    <= '0;
      grant_id <= '0;
      ack      <= '0;
      tx_done  <= 1'b0;
    end else begin
      state_q <= state_d;
      ack     <= grant ? (N_REQ'(1) << winner) : '0;
      tx_done <= (state_q == ST_GAP) && (cnt_q == '0);
      if (grant) begin
        byte_q   <= data_sh[BYTE_W-1:0];
        grant_id <= winner;
        ptr_q    <= (int'(winner) == N_REQ - 1) ? 3'd0 : winner + 3'd1;
      end
      // The counter holds the remaining cycles of whichever timed state comes next.
      case (state_q)
        ST_START: cnt_q <= CNT_W'(FRAME_CYCLES - 1);
        ST_BUSY:  cnt_q <= (cnt_q == '0) ? CNT_W'(GAP_CYCLES - 1) : cnt_q - 1'b1;
        ST_GAP:   if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        default:  cnt_q <= cnt_q;
      endcase
    end
  end

  assign busy            = (state_q != ST_IDLE);
  assign tx.tx_b_ready   = (state_q == ST_ARM);
  assign tx.tx_load_data = (state_q == ST_LOAD);
  assign tx.tx_t_init    = (state_q == ST_START);
  assign tx.tx_data_bus  = byte_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: handshake sequencing, round-robin order,
// enable gating, asynchronous abort and byte capture.
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  ack;
  logic [2:0]  grant_id;
  logic        busy;
  logic        tx_done;

  int checks = 0;
  int failures = 0;

  uart_tx_scheduler_if txif ();

  uart_tx_scheduler #(.N_REQ(4), .FRAME_CYCLES(10), .GAP_CYCLES(2)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .enable   (enable),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .grant_id (grant_id),
    .busy     (busy),
    .tx_done  (tx_done),
    .tx       (txif)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    req = '0; enable = 1'b1; req_data = '0;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_ack(input int max, output int n, output bit ok);
    ok = 1'b0; n = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      n++;
      if (ack != '0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    req = '0; enable = 1'b0; rstn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ack, grant_id, busy, tx_done, txif.tx_data_bus, txif.tx_b_ready,
         txif.tx_load_data, txif.tx_t_init} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: ack=%b gid=%0d busy=%b done=%b data=%h br=%b ld=%b ti=%b expected all 0",
               ack, grant_id, busy, tx_done, txif.tx_data_bus, txif.tx_b_ready,
               txif.tx_load_data, txif.tx_t_init);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int n; bit ok; int bcnt;
    do_reset();
    req_data = 32'h00A5_0000;
    req = 4'b0100;
    wait_ack(10, n, ok);
    req = '0;
    checks++;
    if (!ok || n != 1 || ack !== 4'b0100 || grant_id !== 3'd2) begin
      failures++;
      $display("FAIL single_ack: ok=%0d n=%0d ack=%b gid=%0d expected ack=0100 gid=2 after 1 cycle", ok, n, ack, grant_id);
    end
    checks++;
    if ({txif.tx_b_ready, txif.tx_load_data, txif.tx_t_init} !== 3'b100 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_arm: br/ld/ti=%b busy=%b expected 100 busy=1",
               {txif.tx_b_ready, txif.tx_load_data, txif.tx_t_init}, busy);
    end
    @(negedge clk);
    checks++;
    if ({txif.tx_b_ready, txif.tx_load_data, txif.tx_t_init} !== 3'b010 || ack !== 4'b0000) begin
      failures++;
      $display("FAIL single_load: br/ld/ti=%b ack=%b expected 010 ack=0000",
               {txif.tx_b_ready, txif.tx_load_data, txif.tx_t_init}, ack);
    end
    @(negedge clk);
    checks++;
    if ({txif.tx_b_ready, txif.tx_load_data, txif.tx_t_init} !== 3'b001 || txif.tx_data_bus !== 8'hA5) begin
      failures++;
      $display("FAIL single_start: br/ld/ti=%b data=%h expected 001 data=a5",
               {txif.tx_b_ready, txif.tx_load_data, txif.tx_t_init}, txif.tx_data_bus);
    end
    bcnt = 3;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
      else break;
    end
    checks++;
    if (bcnt != 15 || tx_done !== 1'b1) begin
      failures++;
      $display("FAIL single_busy_len: busy_cycles=%0d done=%b expected 15 done=1", bcnt, tx_done);
    end
    @(negedge clk);
    checks++;
    if (tx_done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_done_pulse: done=%b busy=%b expected 0 0", tx_done, busy);
    end
  endtask

  task automatic test_all_req();
    int n; bit ok;
    logic [2:0] exp_id [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    do_reset();
    req_data = 32'h4433_2211;
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_ack(40, n, ok);
      checks++;
      if (!ok || grant_id !== exp_id[g] || ack !== (4'b0001 << exp_id[g]) ||
          (g > 0 && n != 16)) begin
        failures++;
        $display("FAIL all_req_grant%0d: ok=%0d gid=%0d ack=%b spacing=%0d expected gid=%0d spacing=16",
                 g, ok, grant_id, ack, n, exp_id[g]);
      end
    end
    req = '0;
  endtask

  task automatic test_wrap();
    int n; bit ok;
    do_reset();
    req = 4'b1000;
    wait_ack(10, n, ok);
    req = 4'b1001;
    checks++;
    if (!ok || grant_id !== 3'd3) begin
      failures++;
      $display("FAIL wrap_first: ok=%0d gid=%0d expected 3", ok, grant_id);
    end
    wait_ack(40, n, ok);
    req = 4'b1000;
    checks++;
    if (!ok || grant_id !== 3'd0 || ack !== 4'b0001) begin
      failures++;
      $display("FAIL wrap_second: ok=%0d gid=%0d ack=%b expected gid=0 ack=0001", ok, grant_id, ack);
    end
    wait_ack(40, n, ok);
    req = '0;
    checks++;
    if (!ok || grant_id !== 3'd3 || n != 16) begin
      failures++;
      $display("FAIL wrap_third: ok=%0d gid=%0d spacing=%0d expected gid=3 spacing=16", ok, grant_id, n);
    end
  endtask

  task automatic test_enable();
    int n; bit ok; int acks; bit seen_done;
    do_reset();
    enable = 1'b0;
    req = 4'b0010;
    acks = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ack != '0 || busy) acks++;
    end
    checks++;
    if (acks != 0) begin
      failures++;
      $display("FAIL enable_low_idle: ack_or_busy_cycles=%0d expected 0", acks);
    end
    enable = 1'b1;
    wait_ack(10, n, ok);
    req = 4'b0100;
    checks++;
    if (!ok || grant_id !== 3'd1) begin
      failures++;
      $display("FAIL enable_grant: ok=%0d gid=%0d expected 1", ok, grant_id);
    end
    repeat (5) @(negedge clk);
    enable = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx_done) begin seen_done = 1'b1; break; end
    end
    checks++;
    if (!seen_done) begin
      failures++;
      $display("FAIL enable_frame_completes: tx_done seen=%0d expected 1", seen_done);
    end
    acks = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ack != '0 || busy) acks++;
    end
    checks++;
    if (acks != 0) begin
      failures++;
      $display("FAIL enable_no_regrant: ack_or_busy_cycles=%0d expected 0", acks);
    end
    enable = 1'b1;
    wait_ack(10, n, ok);
    req = '0;
    checks++;
    if (!ok || grant_id !== 3'd2) begin
      failures++;
      $display("FAIL enable_resume: ok=%0d gid=%0d expected 2", ok, grant_id);
    end
  endtask

  task automatic test_reset_mid();
    int n; bit ok;
    do_reset();
    req_data = 32'h0000_00C3;
    req = 4'b0001;
    wait_ack(10, n, ok);
    req = '0;
    repeat (6) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || txif.tx_data_bus !== 8'hC3) begin
      failures++;
      $display("FAIL mid_pre_reset: busy=%b data=%h expected busy=1 data=c3", busy, txif.tx_data_bus);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({ack, grant_id, busy, tx_done, txif.tx_data_bus, txif.tx_b_ready,
         txif.tx_load_data, txif.tx_t_init} !== '0) begin
      failures++;
      $display("FAIL mid_async_reset: gid=%0d busy=%b data=%h expected all 0", grant_id, busy, txif.tx_data_bus);
    end
    @(negedge clk);
    rstn = 1'b1;
    req = 4'b1000;
    wait_ack(10, n, ok);
    req = '0;
    checks++;
    if (!ok || grant_id !== 3'd3 || ack !== 4'b1000) begin
      failures++;
      $display("FAIL mid_after_reset: ok=%0d gid=%0d ack=%b expected gid=3 ack=1000", ok, grant_id, ack);
    end
  endtask

  task automatic test_data_change();
    int n; bit ok; int bad;
    do_reset();
    req_data = 32'h0000_003C;
    req = 4'b0001;
    wait_ack(10, n, ok);
    req = '0;
    @(negedge clk);
    req_data = 32'hFFFF_FFFF;
    req = 4'b0010;
    checks++;
    if (txif.tx_load_data !== 1'b1 || txif.tx_data_bus !== 8'h3C) begin
      failures++;
      $display("FAIL data_load: ld=%b data=%h expected ld=1 data=3c", txif.tx_load_data, txif.tx_data_bus);
    end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (txif.tx_data_bus !== 8'h3C) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL data_held: changed_cycles=%0d data=%h expected 0 changes data=3c", bad, txif.tx_data_bus);
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_req();
    test_wrap();
    test_enable();
    test_reset_mid();
    test_data_change();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
